ext_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle immediate extender.
- Performs immediate extension (sign, zero, upper-load) and load-data extension (byte/half, signed/unsigned, offset-selected) behind a valid/ready pipeline of configurable depth.
- Carries flush and error reporting.
- Used at the ID/EX boundary for immediates and at MEM/WB for load data.

---
 rtl/ext_pkg.sv | 28 ++
 rtl/ext_core.sv | 48 ++++
 rtl/ext_pipe.sv | 115 +++++++++++
 tb/tb_ext_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the pipelined immediate / load-data extender.
//   - op-code encoding (EXT_SEXT .. EXT_RSVD) and its width
//   - error-flag encoding
//   - ext_is_err(): classifies an op/offset pair as illegal
package ext_pkg;

  localparam int EXT_OP_W = 3;

  typedef logic [EXT_OP_W-1:0] ext_op_t;

  localparam ext_op_t EXT_SEXT = 3'd0;  // sign-extend immediate
  localparam ext_op_t EXT_ZEXT = 3'd1;  // zero-extend immediate
  localparam ext_op_t EXT_LUI  = 3'd2;  // immediate placed in the upper bits
  localparam ext_op_t EXT_LB   = 3'd3;  // signed byte load
  localparam ext_op_t EXT_LBU  = 3'd4;  // unsigned byte load
  localparam ext_op_t EXT_LH   = 3'd5;  // signed half load
  localparam ext_op_t EXT_LHU  = 3'd6;  // unsigned half load
  localparam ext_op_t EXT_RSVD = 3'd7;  // reserved, always an error

  localparam logic EXT_ERR_NONE = 1'b0;
  localparam logic EXT_ERR_SET  = 1'b1;

  // Reserved op, or a half load at an odd byte offset.
  function automatic logic ext_is_err(input ext_op_t op, input logic [1:0] off);
    return (op == EXT_RSVD) || (((op == EXT_LH) || (op == EXT_LHU)) && off[0]);
  endfunction

endpackage

// File: rtl/ext_core.sv
// ext_core: purely combinational extender.
//   op     - operation select (ext_op_t)
//   off    - byte offset used by the load modes
//   data   - immediate (low IN_W bits) or loaded word (bits 31:0)
//   result - extended value, 0 on error
//   err    - EXT_ERR_SET for an illegal op or misaligned half load
import ext_pkg::*;

module ext_core #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  ext_op_t           op,
  input  logic [1:0]        off,
  input  logic [OUT_W-1:0]  data,
  output logic [OUT_W-1:0]  result,
  output logic              err
);

  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign word     = data[31:0];
  // Little-endian: offset 0 selects bits 7:0, offset 3 selects bits 31:24.
  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = '0;
    err    = EXT_ERR_NONE;
    if (ext_is_err(op, off)) begin
      err = EXT_ERR_SET;
    end else begin
      case (op)
        EXT_SEXT: result = {{(OUT_W-IN_W){data[IN_W-1]}}, data[IN_W-1:0]};
        EXT_ZEXT: result = {{(OUT_W-IN_W){1'b0}}, data[IN_W-1:0]};
        EXT_LUI:  result = {data[IN_W-1:0], {(OUT_W-IN_W){1'b0}}};
        EXT_LB:   result = {{(OUT_W-8){byte_sel[7]}}, byte_sel};
        EXT_LBU:  result = {{(OUT_W-8){1'b0}}, byte_sel};
        EXT_LH:   result = {{(OUT_W-16){half_sel[15]}}, half_sel};
        EXT_LHU:  result = {{(OUT_W-16){1'b0}}, half_sel};
        default:  result = '0;
      endcase
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extender with flush and error count.
//   clk, reset (async, active-low), flush (sync kill of all in-flight beats)
//   in_valid/in_ready/in_op/in_off/in_data   - input beat
//   out_valid/out_ready/out_data/out_err     - result beat, STAGES cycles deep
//   err_cnt                                  - saturating count of accepted error beats
//
// Handshake: a beat transfers on a port in any cycle where valid and ready are
// both 1 at the rising edge. valid never depends on ready; once out_valid is 1
// it and every out_* field hold until out_ready is seen. in_ready may depend
// combinationally on out_ready through the stage chain.
import ext_pkg::*;

module ext_pipe #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int STAGES    = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXT_OP_W-1:0]  in_op,
  input  logic [1:0]           in_off,
  input  logic [OUT_W-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [OUT_W-1:0]  core_data;
  logic              core_err;

  logic              stg_v [STAGES];
  logic [OUT_W-1:0]  stg_d [STAGES];
  logic              stg_e [STAGES];

  logic              src_v [STAGES];
  logic [OUT_W-1:0]  src_d [STAGES];
  logic              src_e [STAGES];

  // en[k]: stage k may load this edge (it is empty, or its content moves on).
  logic [STAGES-1:0] en;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .op     (in_op),
    .off    (in_off),
    .data   (in_data),
    .result (core_data),
    .err    (core_err)
  );

  always_comb begin
    en = '0;
    en[STAGES-1] = !stg_v[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      en[k] = !stg_v[k] || en[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_src_in
      assign src_v[k] = in_valid;
      assign src_d[k] = core_data;
      assign src_e[k] = core_err;
    end else begin : g_src_prev
      assign src_v[k] = stg_v[k-1];
      assign src_d[k] = stg_d[k-1];
      assign src_e[k] = stg_e[k-1];
    end

    // Only valid bits are killed by flush; payload registers keep whatever
    // they last loaded and are ignored while their valid bit is low.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stg_v[k] <= 1'b0;
        stg_d[k] <= '0;
        stg_e[k] <= EXT_ERR_NONE;
      end else begin
        if (flush) begin
          stg_v[k] <= 1'b0;
        end else if (en[k]) begin
          stg_v[k] <= src_v[k];
        end
        if (en[k] && src_v[k]) begin
          stg_d[k] <= src_d[k];
          stg_e[k] <= src_e[k];
        end
      end
    end
  end

  // A beat presented together with flush is dropped and so never counted;
  // beats already in flight were counted when they were accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (in_valid && in_ready && !flush &&
                 (core_err == EXT_ERR_SET) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign in_ready  = en[0];
  assign out_valid = stg_v[STAGES-1];
  assign out_data  = stg_d[STAGES-1];
  assign out_err   = stg_e[STAGES-1];

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed bench for ext_pipe. Instance a is one stage deep and
// covers the extension ops, errors and counter saturation; instance b is three
// stages deep and covers back-pressure, ordering, flush and latency. Both see
// the mid-stream asynchronous reset.
module tb_ext_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- instance a (STAGES=1) ----------------
  logic        a_flush, a_valid, a_ready, a_ovalid, a_oready, a_oerr;
  logic [2:0]  a_op;
  logic [1:0]  a_off;
  logic [31:0] a_data, a_odata;
  logic [7:0]  a_cnt;

  // ---------------- instance b (STAGES=3) ----------------
  logic        b_flush, b_valid, b_ready, b_ovalid, b_oready, b_oerr;
  logic [2:0]  b_op;
  logic [1:0]  b_off;
  logic [31:0] b_data, b_odata;
  logic [7:0]  b_cnt;

  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1), .ERR_CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_valid), .in_ready(a_ready), .in_op(a_op), .in_off(a_off), .in_data(a_data),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_odata), .out_err(a_oerr),
    .err_cnt(a_cnt)
  );

  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(3), .ERR_CNT_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_valid), .in_ready(b_ready), .in_op(b_op), .in_off(b_off), .in_data(b_data),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata), .out_err(b_oerr),
    .err_cnt(b_cnt)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          idx;
  int          nrecv;

  // Input words and their hand-computed ZEXT results for the b stream.
  logic [31:0] b_in  [5] = '{32'hAAAA_1001, 32'h5555_2002, 32'hFFFF_3003, 32'h0123_4004, 32'h8000_5005};
  logic [31:0] b_exp [5] = '{32'h0000_1001, 32'h0000_2002, 32'h0000_3003, 32'h0000_4004, 32'h0000_5005};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one beat on a for one edge; returns #1 after that edge.
  task automatic a_send(input logic [2:0] op, input logic [1:0] off, input logic [31:0] data);
    a_valid = 1'b1;
    a_op    = op;
    a_off   = off;
    a_data  = data;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  // One cycle on b: observe both handshakes just before the edge, then step.
  task automatic b_cycle();
    #1;
    if (b_ovalid && b_oready) begin
      check("b_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("b_order", b_odata, exp_q.pop_front());
        nrecv++;
      end
    end
    if (b_valid && b_ready) begin
      exp_q.push_back(b_exp[idx]);
      idx++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    a_flush = 1'b0; a_valid = 1'b0; a_oready = 1'b1; a_op = 3'd0; a_off = 2'd0; a_data = '0;
    b_flush = 1'b0; b_valid = 1'b0; b_oready = 1'b1; b_op = 3'd0; b_off = 2'd0; b_data = '0;
    idx = 0;
    nrecv = 0;

    #2;
    check("rst_a_ovalid", 32'(a_ovalid), 32'd0);
    check("rst_a_oerr",   32'(a_oerr),   32'd0);
    check("rst_a_odata",  a_odata,       32'h0);
    check("rst_a_cnt",    32'(a_cnt),    32'd0);
    check("rst_b_ovalid", 32'(b_ovalid), 32'd0);
    check("rst_b_cnt",    32'(b_cnt),    32'd0);

    #10 reset = 1'b1;
    @(posedge clk);
    #1;
    check("a_ready_idle",  32'(a_ready),  32'd1);
    check("a_ovalid_idle", 32'(a_ovalid), 32'd0);

    // Immediate modes, back to back.
    a_send(3'd0, 2'd0, 32'h0000_8001);
    check("a_sext_valid", 32'(a_ovalid), 32'd1);
    check("a_sext",       a_odata,       32'hFFFF_8001);
    check("a_sext_err",   32'(a_oerr),   32'd0);
    a_send(3'd1, 2'd0, 32'h0000_8001);
    check("a_zext",       a_odata,       32'h0000_8001);
    a_send(3'd2, 2'd0, 32'h0000_8001);
    check("a_lui",        a_odata,       32'h8001_0000);
    @(posedge clk);
    #1;
    check("a_one_cycle",  32'(a_ovalid), 32'd0);

    // Load modes.
    a_send(3'd3, 2'd3, 32'h80FF_7F01);
    check("a_lb_off3",    a_odata,       32'hFFFF_FF80);
    a_send(3'd4, 2'd1, 32'h80FF_7F01);
    check("a_lbu_off1",   a_odata,       32'h0000_007F);
    a_send(3'd5, 2'd2, 32'h80FF_7F01);
    check("a_lh_off2",    a_odata,       32'hFFFF_80FF);
    a_send(3'd6, 2'd0, 32'h80FF_7F01);
    check("a_lhu_off0",   a_odata,       32'h0000_7F01);
    check("a_lhu_err",    32'(a_oerr),   32'd0);
    check("a_cnt_clean",  32'(a_cnt),    32'd0);

    // Errors.
    a_send(3'd7, 2'd0, 32'hDEAD_BEEF);
    check("a_rsvd_data",  a_odata,       32'h0);
    check("a_rsvd_err",   32'(a_oerr),   32'd1);
    check("a_rsvd_cnt",   32'(a_cnt),    32'd1);
    a_send(3'd5, 2'd1, 32'h80FF_7F01);
    check("a_lh_mis_err", 32'(a_oerr),   32'd1);
    check("a_lh_mis_data", a_odata,      32'h0);
    check("a_lh_mis_cnt", 32'(a_cnt),    32'd2);

    for (int i = 0; i < 253; i++) a_send(3'd7, 2'(i), 32'(i));
    check("a_cnt_full",   32'(a_cnt),    32'hFF);
    for (int i = 0; i < 47; i++) a_send(3'd6, 2'd3, 32'(i));
    check("a_cnt_sat",    32'(a_cnt),    32'hFF);

    // Back-pressure on b: only three beats fit.
    b_oready = 1'b0;
    b_op     = 3'd1;
    b_off    = 2'd0;
    for (int c = 0; c < 4; c++) begin
      b_valid = (idx < 5);
      if (idx < 5) b_data = b_in[idx];
      b_cycle();
    end
    check("b_accepts",    32'(idx),      32'd3);
    check("b_ready_full", 32'(b_ready),  32'd0);
    check("b_hold_valid", 32'(b_ovalid), 32'd1);
    check("b_hold_data",  b_odata,       32'h0000_1001);
    b_cycle();
    check("b_hold_data2", b_odata,       32'h0000_1001);
    check("b_accepts2",   32'(idx),      32'd3);

    // Release and drain in order.
    b_oready = 1'b1;
    for (int c = 0; c < 20 && nrecv < 5; c++) begin
      b_valid = (idx < 5);
      if (idx < 5) b_data = b_in[idx];
      b_cycle();
    end
    b_valid = 1'b0;
    check("b_recv_count", 32'(nrecv),         32'd5);
    check("b_q_empty",    32'(exp_q.size()),  32'd0);
    check("b_drained",    32'(b_ovalid),      32'd0);

    // Flush with three beats in flight and a fourth presented.
    b_valid = 1'b1;
    b_op = 3'd1; b_data = 32'h0000_F00A;
    @(posedge clk); #1;
    b_op = 3'd7; b_data = 32'h0000_0001;
    @(posedge clk); #1;
    check("b_cnt_err",    32'(b_cnt),    32'd1);
    b_op = 3'd1; b_data = 32'h0000_F00C;
    @(posedge clk); #1;
    check("b_full_valid", 32'(b_ovalid), 32'd1);
    check("b_full_data",  b_odata,       32'h0000_F00A);
    b_op = 3'd1; b_data = 32'h0000_F00D; b_flush = 1'b1;
    #1;
    check("b_ready_flush", 32'(b_ready), 32'd1);
    @(posedge clk); #1;
    b_flush = 1'b0;
    b_valid = 1'b0;
    check("b_flush_clear", 32'(b_ovalid), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("b_flush_quiet", 32'(b_ovalid), 32'd0);
    end
    check("b_cnt_kept",   32'(b_cnt),    32'd1);

    // Latency after flush.
    b_valid = 1'b1; b_op = 3'd0; b_data = 32'h0000_FFFE;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("b_lat_1",      32'(b_ovalid), 32'd0);
    @(posedge clk); #1;
    check("b_lat_2",      32'(b_ovalid), 32'd0);
    @(posedge clk); #1;
    check("b_lat_3",      32'(b_ovalid), 32'd1);
    check("b_lat_data",   b_odata,       32'hFFFF_FFFE);
    check("b_lat_err",    32'(b_oerr),   32'd0);

    // Asynchronous reset between edges.
    a_valid = 1'b1; a_op = 3'd7; a_off = 2'd0; a_data = 32'h0;
    @(posedge clk); #1;
    check("a_pre_reset",  32'(a_ovalid), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("arst_a_ovalid", 32'(a_ovalid), 32'd0);
    check("arst_a_oerr",   32'(a_oerr),   32'd0);
    check("arst_a_cnt",    32'(a_cnt),    32'd0);
    check("arst_b_cnt",    32'(b_cnt),    32'd0);
    a_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("arst_a_ready",  32'(a_ready),  32'd1);
    @(posedge clk); #1;
    a_send(3'd0, 2'd0, 32'h0000_8001);
    check("post_rst_valid", 32'(a_ovalid), 32'd1);
    check("post_rst_data",  a_odata,       32'hFFFF_8001);
    check("post_rst_cnt",   32'(a_cnt),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
